// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, bit-timing helpers and default line settings.
package uart_pkg;
  localparam int unsigned CLOCK_FREQ = 33_000_000;
  localparam int unsigned BAUD_RATE = 115_200;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  function automatic int unsigned symbol_edge_time(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction
  function automatic int unsigned sample_time(input int unsigned freq, input int unsigned baud);
    return symbol_edge_time(freq, baud) / 2;
  endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: ready/valid byte stream from the UART receiver to its consumer.
interface uart_receiver_if;
  logic [7:0] DataOut;
  logic DataOutValid;
  logic DataOutReady;
  modport master (output DataOut, output DataOutValid, input DataOutReady);
  modport slave (input DataOut, input DataOutValid, output DataOutReady);
endinterface

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchronizer for an asynchronous input with a configurable reset level.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q <= RESET_VAL;
    end else begin
      meta <= d;
      q <= meta;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with ready/valid output.
// Define UART_RX_PARITY_EN for 8E1 frames with ParityError reporting.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned ClockFreq = CLOCK_FREQ,
  parameter int unsigned BaudRate = BAUD_RATE
) (
  input  logic Clock,
  input  logic Reset,
  input  logic SIn,
  uart_receiver_if.master byte_if,
  output logic FramingError,
  output logic Overrun,
  output logic ParityError
);
  localparam int unsigned EDGE = symbol_edge_time(ClockFreq, BaudRate);
  localparam int unsigned SAMPLE = sample_time(ClockFreq, BaudRate);
  localparam int unsigned CW = $clog2(EDGE);
  logic rx;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift, data;
  logic valid, tick_half, tick_bit, cnt_clr, stop_ok, stop_bad;
  uart_sync #(.RESET_VAL(1'b1)) u_sync (.clk(Clock), .rst(Reset), .d(SIn), .q(rx));
  assign tick_half = cnt == CW'(SAMPLE - 1);
  assign tick_bit = cnt == CW'(EDGE - 1);
  assign stop_ok = state == STOP && tick_bit && rx;
  assign stop_bad = state == STOP && tick_bit && !rx;
  assign byte_if.DataOut = data;
  assign byte_if.DataOutValid = valid;
  always_comb begin
    state_d = state;
    cnt_clr = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        state_d = rx ? IDLE : START;
      end
      START: if (tick_half) begin
        cnt_clr = 1'b1;
        state_d = rx ? IDLE : DATA;
      end
`ifdef UART_RX_PARITY_EN
      DATA: if (tick_bit) begin
        cnt_clr = 1'b1;
        state_d = bit_cnt == 3'd7 ? PARITY : DATA;
      end
      PARITY: if (tick_bit) begin
        cnt_clr = 1'b1;
        state_d = STOP;
      end
`else
      DATA: if (tick_bit) begin
        cnt_clr = 1'b1;
        state_d = bit_cnt == 3'd7 ? STOP : DATA;
      end
`endif
      STOP: if (tick_bit) begin
        cnt_clr = 1'b1;
        state_d = rx ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        state_d = rx ? IDLE : WAIT_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      data <= '0;
      valid <= 1'b0;
      FramingError <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      FramingError <= stop_bad;
      Overrun <= stop_ok && valid && !byte_if.DataOutReady;
      if (state == START) bit_cnt <= '0;
      if (state == DATA && tick_bit) begin
        shift <= {rx, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (stop_ok && (!valid || byte_if.DataOutReady)) begin
        data <= shift;
        valid <= 1'b1;
      end else if (valid && byte_if.DataOutReady) valid <= 1'b0;
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par_bad;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      par_bad <= 1'b0;
      ParityError <= 1'b0;
    end else begin
      if (state == START) par_bad <= 1'b0;
      if (state == PARITY && tick_bit) par_bad <= rx ^ (^shift);
      ParityError <= stop_ok && (!valid || byte_if.DataOutReady) && par_bad;
    end
  end
`else
  assign ParityError = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames against uart_receiver at 33 MHz / 115200 baud.
module tb_uart_receiver;
  import uart_pkg::*;
  localparam int BIT = 286;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b1;
  logic fe, ov, pe;
  uart_receiver_if bus ();
  uart_receiver #(.ClockFreq(33_000_000), .BaudRate(115_200)) dut (
    .Clock(clk), .Reset(rst), .SIn(sin), .byte_if(bus.master),
    .FramingError(fe), .Overrun(ov), .ParityError(pe)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  int cyc = 0, n_load = 0, n_fe = 0, n_ov = 0, n_pe = 0, n_pe_rise = 0, n_vhi = 0, rise_cyc = 0;
  logic [7:0] last = '0;
  logic v_prev = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    v_prev <= bus.DataOutValid;
    if (!rst) begin
      if (bus.DataOutValid && !v_prev) begin
        n_load <= n_load + 1;
        last <= bus.DataOut;
        rise_cyc <= cyc;
        if (pe) n_pe_rise <= n_pe_rise + 1;
      end
      if (bus.DataOutValid) n_vhi <= n_vhi + 1;
      if (fe) n_fe <= n_fe + 1;
      if (ov) n_ov <= n_ov + 1;
      if (pe) n_pe <= n_pe + 1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask
  task automatic idle(input int n);
    sin = 1'b1;
    hold(n);
  endtask
  int start_cyc;
  task automatic send(input logic [7:0] d, input logic stop, input logic bad_par);
    sin = 1'b0;
    start_cyc = cyc;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      sin = d[i];
      hold(BIT);
    end
`ifdef UART_RX_PARITY_EN
    sin = (^d) ^ bad_par;
    hold(BIT);
`endif
    sin = stop;
    hold(BIT);
  endtask
  int base, vbase;
  initial begin
    bus.DataOutReady = 1'b1;
    hold(5);
    rst = 1'b0;
    #1;
    chk("reset_data", 32'(bus.DataOut), 32'h00);
    chk("reset_valid", 32'(bus.DataOutValid), 32'h0);
    chk("reset_fe", 32'(fe), 32'h0);
    chk("reset_ov", 32'(ov), 32'h0);
    chk("reset_pe", 32'(pe), 32'h0);
    idle(20);
    vbase = n_vhi;
    send(8'hA5, 1'b1, 1'b0);
    idle(600);
    chk("a5_loads", 32'(n_load), 32'd1);
    chk("a5_data", 32'(last), 32'hA5);
    chk("a5_valid_width", 32'(n_vhi - vbase), 32'd1);
    chk("a5_latency", 32'((rise_cyc - start_cyc) >= 2700 && (rise_cyc - start_cyc) <= 2740), 32'd1);
    chk("a5_no_fe", 32'(n_fe), 32'd0);
    chk("a5_no_ov", 32'(n_ov), 32'd0);
    sin = 1'b0;
    hold(50);
    idle(400);
    #1;
    chk("glitch_no_load", 32'(n_load), 32'd1);
    chk("glitch_idle", 32'(dut.state), 32'(IDLE));
    send(8'h3C, 1'b1, 1'b0);
    idle(600);
    chk("3c_loads", 32'(n_load), 32'd2);
    chk("3c_data", 32'(last), 32'h3C);
    send(8'h55, 1'b0, 1'b0);
    hold(2 * BIT);
    idle(600);
    chk("frame_fe", 32'(n_fe), 32'd1);
    chk("frame_no_load", 32'(n_load), 32'd2);
    send(8'h0F, 1'b1, 1'b0);
    idle(600);
    chk("0f_data", 32'(last), 32'h0F);
    chk("0f_loads", 32'(n_load), 32'd3);
    bus.DataOutReady = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    idle(300);
    send(8'h22, 1'b1, 1'b0);
    idle(600);
    #1;
    chk("ovr_data", 32'(bus.DataOut), 32'h11);
    chk("ovr_valid", 32'(bus.DataOutValid), 32'h1);
    chk("ovr_pulse", 32'(n_ov), 32'd1);
    @(posedge clk);
    bus.DataOutReady = 1'b1;
    hold(2);
    #1;
    chk("ovr_drained", 32'(bus.DataOutValid), 32'h0);
    base = n_load;
    sin = 1'b0;
    hold(BIT);
    sin = 1'b1;
    hold(4 * BIT + BIT / 2);
    rst = 1'b1;
    hold(2);
    rst = 1'b0;
    #1;
    chk("midrst_data", 32'(bus.DataOut), 32'h00);
    chk("midrst_valid", 32'(bus.DataOutValid), 32'h0);
    idle(3000);
    send(8'h81, 1'b1, 1'b0);
    idle(600);
    chk("81_loads", 32'(n_load - base), 32'd1);
    chk("81_data", 32'(last), 32'h81);
`ifdef UART_RX_PARITY_EN
    chk("par_ok_none", 32'(n_pe), 32'd0);
    send(8'h07, 1'b1, 1'b1);
    idle(600);
    chk("par_data", 32'(last), 32'h07);
    chk("par_pulse", 32'(n_pe), 32'd1);
    chk("par_with_rise", 32'(n_pe_rise), 32'd1);
`else
    chk("no_parity_pulse", 32'(n_pe), 32'd0);
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
